// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the 32x64 architectural register file
package regfile_pkg;

  localparam int        REG_W = 64;
  localparam int        NREGS = 32;
  localparam logic [4:0] XZR  = 5'd31;

  typedef logic [4:0]       reg_addr_t;
  typedef logic [REG_W-1:0] word_t;

endpackage

// File: rtl/regfile_64x32_if.sv
// rtl/regfile_64x32_if.sv - write port and two read ports of the register file
interface regfile_64x32_if;
  import regfile_pkg::*;

  logic      RegWrite;
  reg_addr_t WriteRegister;
  word_t     WriteData;
  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  word_t     ReadData1;
  word_t     ReadData2;

  // decode stage side: drives addresses and write data, consumes operands
  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  // register file side
  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/decoder_5x32.sv
// rtl/decoder_5x32.sv - enable-gated 5-to-32 one-hot decoder
module decoder_5x32 (
  input  logic [4:0]  in,
  input  logic        en,
  output logic [31:0] out
);

  // raise only the addressed line, and only when enabled; an unknown enable selects nothing
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/mux_64x32x1.sv
// rtl/mux_64x32x1.sv - one 64-bit 32:1 read mux over the register array
module mux_64x32x1
  import regfile_pkg::*;
(
  input  word_t [31:0] data,
  input  reg_addr_t    sel,
  output word_t        out
);

  assign out = data[sel];

endmodule

// File: rtl/regfile_64x32.sv
// rtl/regfile_64x32.sv - 32x64 register file, one write port, two combinational read ports, XZR at 31
module regfile_64x32
  import regfile_pkg::REG_W;
  import regfile_pkg::XZR;
  import regfile_pkg::word_t;
#(
  parameter int WIDTH  = REG_W,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_64x32_if.slave        bus
);

  // A write is real only out of reset and never to XZR, so the decoder line for
  // entry 31 can never fire and the same vector doubles as the forwarding hit map.
  logic             wr_valid;
  logic [NREGS-1:0] wr_en;
  word_t [31:0]     reg_view;
  word_t            mux_rd1;
  word_t            mux_rd2;
  logic             hit1;
  logic             hit2;

  assign wr_valid = reset_n & bus.RegWrite & (bus.WriteRegister != XZR);

  decoder_5x32 u_wr_dec (
    .in  (bus.WriteRegister),
    .en  (wr_valid),
    .out (wr_en)
  );

  for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
    logic [WIDTH-1:0] q;

    // entry i: cleared asynchronously by reset, loaded when its decoder line fires
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      q <= '0;
      else if (wr_en[i]) q <= bus.WriteData;
    end

    assign reg_view[i] = q;
  end

  // XZR is a constant mux input, not storage
  assign reg_view[XZR] = '0;

  mux_64x32x1 u_rd1_mux (
    .data (reg_view),
    .sel  (bus.ReadRegister1),
    .out  (mux_rd1)
  );

  mux_64x32x1 u_rd2_mux (
    .data (reg_view),
    .sel  (bus.ReadRegister2),
    .out  (mux_rd2)
  );

  // Same-cycle forwarding: wr_en already excludes reset and XZR
  assign hit1 = BYPASS && wr_en[bus.ReadRegister1];
  assign hit2 = BYPASS && wr_en[bus.ReadRegister2];

  assign bus.ReadData1 = hit1 ? bus.WriteData : mux_rd1;
  assign bus.ReadData2 = hit2 ? bus.WriteData : mux_rd2;

endmodule
